mpx_rr_arbiter: RTL and testbench



---
 rtl/mpx_rr_arbiter_if.sv | 13 +
 rtl/mpx_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mpx_rr_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mpx_rr_arbiter_if.sv
// Requester-side bundle for the round-robin mux-select arbiter.
// The master drives requests and releases; the slave (the arbiter) drives the select.
interface mpx_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] sel;
  logic       grant_valid;
  logic [1:0] owner;
  logic       timeout;

  modport master (output req, done, input sel, grant_valid, owner, timeout);
  modport slave  (input req, done, output sel, grant_valid, owner, timeout);
endinterface

// File: rtl/mpx_rr_arbiter.sv
// Round-robin owner of a 4:1 one-hot operand mux with a bounded hold time.
// The select always drops to zero for one cycle between owners.
module mpx_rr_arbiter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic             clk,
  input logic             rst_n,
  mpx_rr_arbiter_if.slave bus
);

  localparam bit               LIM_EN    = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       owner_q, owner_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       scan_idx;
  logic             rel_done, rel_req, rel_lim;

  // First requester at or above ptr, wrapping 3 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;

    rel_done = bus.done[owner_q];
    rel_req  = !bus.req[owner_q];
    rel_lim  = LIM_EN && (hold_cnt_q == HOLD_LAST);

    unique case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d    = GRANT;
          sel_d      = 4'b0001 << win_idx;
          owner_d    = win_idx;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
          sel_d   = 4'b0000;
          owner_d = 2'd0;
        end
      end
      GRANT: begin
        if (rel_done || rel_req || rel_lim) begin
          state_d    = GAP;
          sel_d      = 4'b0000;
          owner_d    = 2'd0;
          ptr_d      = owner_q + 2'd1;
          hold_cnt_d = '0;
          // Timeout is flagged only when the limit was the sole cause.
          timeout_d  = rel_lim && !rel_done && !rel_req;
        end else if (LIM_EN && (hold_cnt_q != HOLD_LAST)) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 4'b0000;
        owner_d = 2'd0;
      end
    endcase

    grant_valid_d = |sel_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      hold_cnt_q    <= '0;
      sel_q         <= 4'b0000;
      owner_q       <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      sel_q         <= sel_d;
      owner_q       <= owner_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.owner       = owner_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mpx_rr_arbiter.sv
// Self-checking bench for mpx_rr_arbiter: per-cycle vector table with a scoreboard
// queue of expected outputs, plus a hand-written asynchronous-reset sequence.
module tb_mpx_rr_arbiter;

  typedef struct packed {
    logic [3:0] sel;
    logic       gv;
    logic [1:0] owner;
    logic       to;
  } out_t;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] done;
    out_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  mpx_rr_arbiter_if bus ();

  mpx_rr_arbiter #(.CNT_W(8), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic out_t outs_now();
    out_t o;
    o.sel   = bus.sel;
    o.gv    = bus.grant_valid;
    o.owner = bus.owner;
    o.to    = bus.timeout;
    return o;
  endfunction

  task automatic check(input string name, input int idx, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got sel=%b gv=%b owner=%0d timeout=%b, want sel=%b gv=%b owner=%0d timeout=%b",
               name, idx, act.sel, act.gv, act.owner, act.to, exp.sel, exp.gv, exp.owner, exp.to);
    end
  endtask

  // Expected outputs are those visible after the edge that samples req/done.
  task automatic add(input bit rst, input logic [3:0] req, input logic [3:0] done,
                     input logic [3:0] sel, input logic [1:0] owner, input logic to);
    vec_t v;
    v.rst       = rst;
    v.req       = req;
    v.done      = done;
    v.exp.sel   = sel;
    v.exp.gv    = (sel != 4'b0000);
    v.exp.owner = owner;
    v.exp.to    = to;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input int idx);
    out_t zero;
    zero = '0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", idx, outs_now(), zero);
    rst_n = 1'b1;
  endtask

  task automatic step(input string name, input int idx, input logic [3:0] req,
                      input logic [3:0] done, input out_t exp);
    out_t e;
    bus.req  = req;
    bus.done = done;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s[%0d]: scoreboard empty", name, idx);
    end else begin
      e = exp_q.pop_front();
      check(name, idx, outs_now(), e);
    end
  endtask

  initial begin
    out_t e;
    logic [3:0] oh;

    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;

    // Single requester, released by done.
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    add(0, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // All requesting: rotation with a zero cycle between owners.
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      add(k == 0, 4'b1111, 4'b0000, oh, 2'(k), 1'b0);
      add(0, 4'b1111, 4'b0000, oh, 2'(k), 1'b0);
      add(0, 4'b1111, 4'b0000, oh, 2'(k), 1'b0);
      add(0, 4'b1111, oh, 4'b0000, 2'd0, 1'b0);
    end
    add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Sole requester hits the hold limit: 16 grant cycles then a timeout gap.
    for (int k = 0; k < 16; k++)
      add(k == 0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
    add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // done coinciding with the limit is a normal release.
    for (int k = 0; k < 16; k++)
      add(k == 0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Non-owner done and req toggling ignored; owner req drop releases.
    add(1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    add(0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b0);
    add(0, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b0);
    add(0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b0);
    add(0, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Requester that drops before being sampled gets nothing.
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(i);
      step("vec", i, tbl[i].req, tbl[i].done, tbl[i].exp);
    end

    // Asynchronous reset in the middle of a grant, then pointer restarts at 0.
    do_reset(900);
    e = '{sel: 4'b0010, gv: 1'b1, owner: 2'd1, to: 1'b0};
    step("async", 0, 4'b0010, 4'b0000, e);
    step("async", 1, 4'b0010, 4'b0000, e);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_now", 2, outs_now(), out_t'('0));
    @(posedge clk);
    #1;
    check("async_rst_hold", 3, outs_now(), out_t'('0));
    rst_n = 1'b1;
    e = '{sel: 4'b0001, gv: 1'b1, owner: 2'd0, to: 1'b0};
    step("async", 4, 4'b0011, 4'b0000, e);
    e = '0;
    step("async", 5, 4'b0011, 4'b0001, e);
    e = '{sel: 4'b0010, gv: 1'b1, owner: 2'd1, to: 1'b0};
    step("async", 6, 4'b0011, 4'b0000, e);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
